inst_cache: RTL

Direct-mapped, read-only instruction cache between the pipeline core's instruction fetch port (`inst_ren`/`inst_addr`/`inst_data`) and a slower backing instruction memory with a request/acknowledge burst interface. Hits return data in the same cycle with no stall. Misses assert `inst_stall`, which the core's controller ORs into its IF/ID stall. The cache refills one full line, then resumes.

---
 rtl/inst_cache_pkg.sv | 34 +++
 rtl/inst_cache_if.sv | 40 ++++
 rtl/inst_cache_array.sv | 64 ++++++
 rtl/inst_cache.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/inst_cache_pkg.sv
// Shared types, geometry helpers and constants for the instruction cache.
package inst_cache_pkg;

    // Controller states; the encoding is fixed so traces read the same everywhere.
    typedef enum logic {
        StIdle = 1'b0,
        StFill = 1'b1
    } state_e;

    // Statistics counters stop here instead of wrapping.
    localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

    // Word-offset bits within a line.
    function automatic int unsigned calc_off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Index bits selecting a line.
    function automatic int unsigned calc_idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Tag bits: whatever remains of the 30-bit word address.
    function automatic int unsigned calc_tag_w(input int unsigned line_words,
                                               input int unsigned lines);
        return 30 - calc_off_w(line_words) - calc_idx_w(lines);
    endfunction

    // Saturating increment for the statistics counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        return (val == CntMax) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Fetch-port and refill-bus signals of the instruction cache.
// slave: the cache's view; master: the core + backing memory side.
interface inst_cache_if;

    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        inv;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  inst_ren,
        input  inst_addr,
        input  inv,
        input  mem_ack,
        input  mem_rdata,
        output inst_data,
        output inst_stall,
        output mem_req,
        output mem_addr
    );

    modport master (
        output inst_ren,
        output inst_addr,
        output inv,
        output mem_ack,
        output mem_rdata,
        input  inst_data,
        input  inst_stall,
        input  mem_req,
        input  mem_addr
    );

endinterface

// File: rtl/inst_cache_array.sv
// Tag, valid and data storage for the direct-mapped cache.
// Reads are asynchronous; writes, tag updates and clear-all are synchronous.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64,
    localparam int unsigned OffW      = calc_off_w(LINE_WORDS),
    localparam int unsigned IdxW      = calc_idx_w(LINES),
    localparam int unsigned TagW      = calc_tag_w(LINE_WORDS, LINES)
) (
    input  logic            clk,
    input  logic            rst,
    // lookup port
    input  logic [IdxW-1:0] rd_idx,
    input  logic [OffW-1:0] rd_off,
    output logic            rd_valid,
    output logic [TagW-1:0] rd_tag,
    output logic [31:0]     rd_data,
    // refill port
    input  logic            data_we,
    input  logic [IdxW-1:0] wr_idx,
    input  logic [OffW-1:0] wr_off,
    input  logic [31:0]     wr_data,
    input  logic            line_we,
    input  logic            line_valid,
    input  logic [TagW-1:0] wr_tag,
    input  logic            clr_all
);

    logic [31:0]     data_mem [LINES][LINE_WORDS];
    logic [TagW-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid_q;

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx][rd_off];

    // Refill beat write; data storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[wr_idx][wr_off] <= wr_data;
        end
    end

    // Tag write at line completion; not reset, valid bits guard it.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[wr_idx] <= wr_tag;
        end
    end

    // Valid bits: clear-all takes priority over a line completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (line_we) begin
            valid_q[wr_idx] <= line_valid;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, line refill
// over a req/ack burst bus on a miss, whole-cache invalidate, hit/miss stats.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64
) (
    input  logic         clk,
    input  logic         rst,
    inst_cache_if.slave  bus,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
);

    localparam int unsigned OffW = calc_off_w(LINE_WORDS);
    localparam int unsigned IdxW = calc_idx_w(LINES);
    localparam int unsigned TagW = calc_tag_w(LINE_WORDS, LINES);
    localparam logic [OffW-1:0] LastBeat = OffW'(LINE_WORDS - 1);

    // Current fetch address split.
    logic [OffW-1:0] cur_off;
    logic [IdxW-1:0] cur_idx;
    logic [TagW-1:0] cur_tag;
    logic            unused_addr;

    assign cur_off     = bus.inst_addr[2 +: OffW];
    assign cur_idx     = bus.inst_addr[2 + OffW +: IdxW];
    assign cur_tag     = bus.inst_addr[31 -: TagW];
    assign unused_addr = ^bus.inst_addr[1:0];

    // Storage interface.
    logic            rd_valid;
    logic [TagW-1:0] rd_tag;
    logic [31:0]     rd_data;
    logic            data_we;
    logic            line_we;
    logic            line_valid;
    logic            clr_all;

    // Controller state.
    state_e          state_q, state_d;
    logic [OffW-1:0] beat_q, beat_d;
    logic            inv_pend_q, inv_pend_d;
    logic [TagW-1:0] fill_tag_q, fill_tag_d;
    logic [IdxW-1:0] fill_idx_q, fill_idx_d;
    logic            mem_req_q, mem_req_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    logic            hit;

    inst_cache_array #(
        .LINE_WORDS (LINE_WORDS),
        .LINES      (LINES)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx     (cur_idx),
        .rd_off     (cur_off),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .data_we    (data_we),
        .wr_idx     (fill_idx_q),
        .wr_off     (beat_q),
        .wr_data    (bus.mem_rdata),
        .line_we    (line_we),
        .line_valid (line_valid),
        .wr_tag     (fill_tag_q),
        .clr_all    (clr_all)
    );

    assign hit = rd_valid & (rd_tag == cur_tag);

    // Fetch-side outputs are purely combinational off the lookup.
    assign bus.inst_data  = rd_data;
    assign bus.inst_stall = bus.inst_ren & ((state_q != StIdle) | ~hit);
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

    // Next-state, refill write strobes and counter updates.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        inv_pend_d = inv_pend_q;
        fill_tag_d = fill_tag_q;
        fill_idx_d = fill_idx_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        data_we    = 1'b0;
        line_we    = 1'b0;
        line_valid = 1'b0;
        clr_all    = bus.inv;

        case (state_q)
            StIdle: begin
                if (bus.inst_ren) begin
                    if (hit) begin
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        // A coincident inv still clears; the miss proceeds.
                        state_d    = StFill;
                        fill_tag_d = cur_tag;
                        fill_idx_d = cur_idx;
                        beat_d     = '0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {cur_tag, cur_idx, {(OffW + 2){1'b0}}};
                        miss_cnt_d = sat_inc(miss_cnt_q);
                    end
                end
            end
            StFill: begin
                inv_pend_d = inv_pend_q | bus.inv;
                if (bus.mem_ack) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        // An invalidate seen at any point of the burst,
                        // including this beat, leaves the line invalid.
                        line_we    = 1'b1;
                        line_valid = ~(inv_pend_q | bus.inv);
                        beat_d     = '0;
                        inv_pend_d = 1'b0;
                        mem_req_d  = 1'b0;
                        state_d    = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Controller, bus and statistics registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            inv_pend_q <= 1'b0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            inv_pend_q <= inv_pend_d;
            fill_tag_q <= fill_tag_d;
            fill_idx_q <= fill_idx_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule
